// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage ahead of the datapath shifter.
// Holds an NREGS x DATA_W register file plus the A/B operand registers.
// An accepted start reads R[rn] into A, then R[rm] into B, and then
// presents A, B and the shift code with a one-cycle valid.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (priority over start/wr_en)
//   wr_en      register-file write enable
//   wr_addr    write register index
//   wr_data    write data
//   start      fetch request, accepted in IDLE or DONE only
//   rn         operand A register index, sampled with accepted start
//   rm         operand B register index, sampled with accepted start
//   shift_in   shift code, sampled with accepted start
//   busy       high while reading (READ_A, READ_B)
//   valid      high for the single DONE cycle
//   a_out      operand A register
//   b_out      operand B register (shifter data input)
//   shift_out  latched shift code (shifter control)
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [AW-1:0]     rn,
  input  logic [AW-1:0]     rm,
  input  logic [1:0]        shift_in,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [AW-1:0]     rn_q, rn_d;
  logic [AW-1:0]     rm_q, rm_d;
  logic [1:0]        shift_q, shift_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rd_a, rd_b;

  // A write landing on the same edge as an operand read is forwarded so the
  // operand sees the new value rather than the stale register contents.
  always_comb begin
    rd_a = regs_q[rn_q];
    if (wr_en && (wr_addr == rn_q)) rd_a = wr_data;
    rd_b = regs_q[rm_q];
    if (wr_en && (wr_addr == rm_q)) rd_b = wr_data;
  end

  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    shift_d = shift_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rn_d    = rn;
          rm_d    = rm;
          shift_d = shift_in;
          state_d = READ_A;
        end else begin
          state_d = IDLE;
        end
      end
      READ_A: begin
        a_d     = rd_a;
        state_d = READ_B;
      end
      READ_B: begin
        b_d     = rd_b;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      shift_q <= shift_d;
      a_q     <= a_d;
      b_q     <= b_d;
      if (wr_en) regs_q[wr_addr] <= wr_data;
    end
  end

  assign busy      = (state_q == READ_A) || (state_q == READ_B);
  assign valid     = (state_q == DONE);
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign shift_out = shift_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [2:0]  rn, rm;
  logic [1:0]  shift_in;
  logic        busy, valid;
  logic [15:0] a_out, b_out;
  logic [1:0]  shift_out;

  int n_total = 0;
  int n_bad   = 0;

  operand_fetch #(.DATA_W(16), .NREGS(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rn(rn), .rm(rm), .shift_in(shift_in),
    .busy(busy), .valid(valid),
    .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  // One-cycle start pulse, then walk to DONE checking the handshake.
  task automatic run_fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    rn = a; rm = b; shift_in = s; start = 1'b1;
    step();
    start = 1'b0;
    check("busy_rda", {31'd0, busy}, 32'd1);
    check("valid_rda", {31'd0, valid}, 32'd0);
    step();
    check("busy_rdb", {31'd0, busy}, 32'd1);
    step();
    check("valid_done", {31'd0, valid}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_ops(input string tag, input logic [15:0] ea, input logic [15:0] eb, input logic [1:0] es);
    check({tag, "_a"}, {16'd0, a_out}, {16'd0, ea});
    check({tag, "_b"}, {16'd0, b_out}, {16'd0, eb});
    check({tag, "_sh"}, {30'd0, shift_out}, {30'd0, es});
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; rn = '0; rm = '0; shift_in = '0;
    step(); step();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check_ops("rst", 16'h0000, 16'h0000, 2'b00);

    // 1: zero fetch after reset
    run_fetch(3'd0, 3'd0, 2'b00);
    check_ops("t1", 16'h0000, 16'h0000, 2'b00);
    step();
    check("t1_valid_off", {31'd0, valid}, 32'd0);

    // 2: basic fetch
    write_reg(3'd3, 16'h1234);
    write_reg(3'd5, 16'hF00F);
    run_fetch(3'd3, 3'd5, 2'b10);
    check_ops("t2", 16'h1234, 16'hF00F, 2'b10);
    step();
    check("t2_valid_off", {31'd0, valid}, 32'd0);

    // 3: forwarding into B during READ_B
    rn = 3'd3; rm = 3'd5; shift_in = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t3_busy_rdb", {31'd0, busy}, 32'd1);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hAAAA;
    step();
    wr_en = 1'b0;
    check("t3_valid", {31'd0, valid}, 32'd1);
    check_ops("t3", 16'h1234, 16'hAAAA, 2'b01);
    step();
    run_fetch(3'd5, 3'd5, 2'b00);
    check_ops("t3_r5", 16'hAAAA, 16'hAAAA, 2'b00);
    step();

    // 3b: forwarding into A during READ_A
    rn = 3'd4; rm = 3'd3; shift_in = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5A5A;
    step();
    wr_en = 1'b0;
    step();
    check_ops("t3b", 16'h5A5A, 16'h1234, 2'b11);
    step();
    write_reg(3'd5, 16'hF00F);

    // 4: same register for both operands
    write_reg(3'd2, 16'h8001);
    run_fetch(3'd2, 3'd2, 2'b11);
    check_ops("t4", 16'h8001, 16'h8001, 2'b11);
    step();

    // 5: start held through busy, then back-to-back from DONE
    rn = 3'd3; rm = 3'd5; shift_in = 2'b01; start = 1'b1;
    step();
    rn = 3'd2; rm = 3'd2; shift_in = 2'b11;
    step();
    step();
    check("t5_valid", {31'd0, valid}, 32'd1);
    check_ops("t5a", 16'h1234, 16'hF00F, 2'b01);
    rn = 3'd5; rm = 3'd3; shift_in = 2'b10;
    step();
    start = 1'b0;
    check("t5_b2b_busy", {31'd0, busy}, 32'd1);
    check("t5_b2b_valid", {31'd0, valid}, 32'd0);
    step();
    step();
    check("t5_b2b_done", {31'd0, valid}, 32'd1);
    check_ops("t5b", 16'hF00F, 16'h1234, 2'b10);
    step();

    // 6: reset in READ_B aborts the fetch and clears the register file
    rn = 3'd3; rm = 3'd3; shift_in = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t6_busy_rdb", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_valid", {31'd0, valid}, 32'd0);
    check_ops("t6", 16'h0000, 16'h0000, 2'b00);
    step();
    check("t6_novalid1", {31'd0, valid}, 32'd0);
    step();
    check("t6_novalid2", {31'd0, valid}, 32'd0);
    run_fetch(3'd3, 3'd5, 2'b01);
    check_ops("t6_refetch", 16'h0000, 16'h0000, 2'b01);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage directly upstream of the datapath shifter: 8 x 16-bit register file plus A/B operand registers.
- On a start request, a small FSM reads Rn into A, then Rm into B, over two cycles.
- It then presents A, B and the latched shift code for one valid cycle.
- b_out/shift_out drive the shifter inputs; a_out drives the ALU's other operand.

Parameters:
DATA_W, 16, register and operand width
NREGS, 8, number of registers
AW, 3, register address width (log2 NREGS)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  register-file write enable
wr_addr  input  AW  write register index
wr_data  input  DATA_W  write data
start  input  1  fetch request; accepted only in IDLE or DONE
rn  input  AW  register index for operand A; sampled with accepted start
rm  input  AW  register index for operand B; sampled with accepted start
shift_in  input  2  shift code for this operation; sampled with accepted start
busy  output  1  high in READ_A and READ_B
valid  output  1  high for exactly one cycle in DONE
a_out  output  DATA_W  operand A register
b_out  output  DATA_W  operand B register, feeds shifter data input
shift_out  output  2  latched shift code, feeds shifter control

Behaviour:
- Reset (synchronous, active-high, clk only):
  - State goes to IDLE.
  - All NREGS registers clear to 0.
  - a_out, b_out and shift_out clear to 0; busy and valid are 0.
  - Reset has priority over start and wr_en in the same cycle.
- Register file:
  - Write when wr_en=1 at a rising edge: R[wr_addr] <= wr_data.
  - Writes are allowed in every state, independent of the FSM.
- FSM states: IDLE, READ_A, READ_B, DONE.
  - IDLE: start=1 at edge N latches rn, rm and shift_in into internal rn_q, rm_q and shift_out; next state READ_A. Otherwise stay in IDLE.
  - READ_A: at edge N+1, A <= R[rn_q]; next state READ_B.
  - READ_B: at edge N+2, B <= R[rm_q]; next state DONE.
  - DONE: valid=1 for this one cycle.
    - start=1 at edge N+3 latches new indices and shift code; next state READ_A (back-to-back fetch).
    - Otherwise next state IDLE.
- Latency and hold:
  - valid is asserted two cycles after the start-accept edge and lasts exactly one cycle.
  - busy is high for exactly the two read cycles.
- Outputs decode from state (Moore): busy = READ_A|READ_B; valid = DONE.
- start while busy (READ_A/READ_B) is ignored and never queued; indices latched earlier are unchanged.
- Write forwarding: if wr_en=1 and wr_addr equals the index being read on the same edge, the operand register takes wr_data, not the old register value. This applies to READ_A/rn_q and READ_B/rm_q.
- rn_q == rm_q is legal: both operands read the same register, each with forwarding checked at its own edge.
- No arithmetic is performed; all widths are DATA_W; no truncation or extension.
- Out-of-range indices cannot occur (AW bits address exactly NREGS entries).
- Reset mid-operation: abort to IDLE and clear everything as above; no valid pulse follows for the aborted fetch.

Test Plan:
1. Reset, then start with rn=0, rm=0, shift_in=00 -> busy high 2 cycles, then valid for 1 cycle with a_out=0x0000, b_out=0x0000, shift_out=00.
2. Write R3=0x1234, R5=0xF00F; start with rn=3, rm=5, shift_in=10 -> valid 2 cycles after accept with a_out=0x1234, b_out=0xF00F, shift_out=10; valid low the following cycle.
3. Forwarding: R5=0xF00F; start with rn=3, rm=5; during the READ_B cycle drive wr_en=1, wr_addr=5, wr_data=0xAAAA -> b_out=0xAAAA and R5 reads 0xAAAA afterwards.
4. Same-register read: R2=0x8001; start with rn=2, rm=2, shift_in=11 -> a_out=b_out=0x8001, shift_out=11.
5. Handshake:
   - start held high through READ_A/READ_B with different rn/rm values -> results reflect only the first request.
   - start=1 in DONE with rn=5, rm=3 -> READ_A next cycle, a_out=0xF00F, b_out=0x1234 two cycles later, no idle gap.
6. Reset asserted in READ_B after R3=0x1234 -> next cycle busy=0, valid=0, a_out=0, shift_out=00; no valid pulse follows; a new fetch of R3 returns 0x0000.
